// File: rtl/led_pattern_gen.sv
// LED pattern engine: a prescaled tick steps a pattern register (count, chase, bounce or blink).
// A free-running PWM counter gates the registered pattern onto the LED bank for brightness control.
module led_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int DIV      = 50_000_000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                pause,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_data,
  input  logic [PWM_BITS-1:0] bright,
  output logic [WIDTH-1:0]    led,
  output logic                tick
);

  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  logic [PRE_W-1:0]    pre;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [WIDTH-1:0]    pat;
  logic [WIDTH-1:0]    pat_nxt;
  logic                dir;
  logic                dir_nxt;
  logic                tick_int;
  logic                pwm_on;
  mode_e               mode_sel;

  assign tick_int = (pre == PRE_MAX);
  assign pwm_on   = (pwm_cnt < bright);
  assign mode_sel = mode_e'(mode);

  // Load beats a step; a step happens only on an unpaused tick.
  always_comb begin
    pat_nxt = pat;
    dir_nxt = dir;
    if (load) begin
      pat_nxt = load_data;
      dir_nxt = 1'b0;
    end else if (tick_int && !pause) begin
      case (mode_sel)
        MODE_COUNT: pat_nxt = pat + WIDTH'(1);
        MODE_CHASE: begin
          if (pat == '0) begin
            pat_nxt = WIDTH'(1);
            dir_nxt = 1'b0;
          end else begin
            pat_nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};
          end
        end
        MODE_BOUNCE: begin
          // An empty pattern would never light anything, so reseed instead of shifting.
          if (pat == '0) begin
            pat_nxt = WIDTH'(1);
            dir_nxt = 1'b0;
          end else if (!dir) begin
            if (pat[WIDTH-1]) begin
              pat_nxt = pat >> 1;
              dir_nxt = 1'b1;
            end else begin
              pat_nxt = pat << 1;
            end
          end else begin
            if (pat[0]) begin
              pat_nxt = pat << 1;
              dir_nxt = 1'b0;
            end else begin
              pat_nxt = pat >> 1;
            end
          end
        end
        default: pat_nxt = ~pat;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre     <= '0;
      pwm_cnt <= '0;
      pat     <= WIDTH'(1);
      dir     <= 1'b0;
      led     <= '0;
      tick    <= 1'b0;
    end else begin
      pre     <= tick_int ? '0 : pre + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      pat     <= pat_nxt;
      dir     <= dir_nxt;
      // Output stage: pattern and PWM gate land on the pins one cycle later.
      led     <= pwm_on ? pat : '0;
      tick    <= tick_int;
    end
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine for the Nexys3 LED bank. It is the next generation of the fixed `led_top` output stage. It drives a WIDTH-bit LED vector from a registered pattern that advances on a programmable prescaled tick, in one of four modes: count, chase, bounce or blink. A free-running PWM counter scales global brightness. A processor-side load port lets the PicoBlaze host preset the pattern at any time.

## Interface
- WIDTH, 8, number of LEDs/pattern bits (≥2)
- DIV, 50_000_000, clk cycles per pattern step (≥2); prescaler width = clog2(DIV)
- PWM_BITS, 4, brightness resolution; PWM period = 2^PWM_BITS cycles
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- mode  in  2  0=count, 1=chase, 2=bounce, 3=blink; sampled on tick
- pause  in  1  1 = hold pattern; prescaler keeps running
- load  in  1  single-cycle strobe: pattern <= load_data
- load_data  in  WIDTH  value written on load
- bright  in  PWM_BITS  duty: LEDs on while pwm_cnt < bright
- led  out  WIDTH  registered pattern gated by PWM
- tick  out  1  registered one-cycle pulse each step boundary

## Operation
- Prescaler `pre` counts 0..DIV-1 and wraps. tick_int = (pre == DIV-1). `tick` output is tick_int registered.
- Pattern register `pat[WIDTH-1:0]` and direction flag `dir` (0=left, 1=right) update with this priority:
  1. load=1: pat <= load_data, dir <= 0. This wins over tick and pause.
  2. tick_int & !pause: step per mode, below.
  3. Otherwise: hold.
- Step rules:
  - count: pat <= pat + 1, modulo 2^WIDTH; all-ones wraps to 0.
  - chase: rotate left; pat[WIDTH-1] moves to bit 0.
  - bounce, dir=0: if pat[WIDTH-1] then pat <= pat>>1 and dir <= 1, else pat <= pat<<1.
  - bounce, dir=1: if pat[0] then pat <= pat<<1 and dir <= 0, else pat <= pat>>1.
  - blink: pat <= ~pat.
  - chase/bounce with pat==0 at tick: pat <= 1 and dir <= 0 (reseed). No shift occurs that step.
- Mode change takes effect at the next step only. pat and dir are not reset by a mode change.
- PWM: `pwm_cnt` (PWM_BITS) free-runs and wraps. on = (pwm_cnt < bright).
  - bright=0 keeps LEDs dark.
  - bright=2^PWM_BITS-1 gives (2^PWM_BITS-1)/2^PWM_BITS duty.
- led <= on ? pat : 0 (registered).

## Timing
- Reset values: pre=0, pwm_cnt=0, pat=1 (bit 0 set), dir=0, led=0, tick=0.
- After rst deasserts, the first tick_int occurs at cycle DIV-1. `tick` asserts one cycle later, and the new pat is visible in the same cycle as `tick`.
- led latency: one cycle after pat and pwm_cnt change.
- load at cycle n: pat = load_data at n+1, led reflects it at n+2 (if PWM on). The prescaler is not disturbed.
- load coinciding with tick_int: load wins and that step is lost. `tick` still pulses.
- pause does not suppress `tick`.
- Reset asserted mid-operation clears all state immediately (asynchronous). Outputs go to reset values without waiting for clk.

## Test plan
- Reset/count, with DIV=4, PWM_BITS=4, bright=15, mode=0: after rst release, pat steps 1→2→3 with tick every 4 cycles. Preload 8'hFF; the next step gives 8'h00.
- Chase/bounce, with WIDTH=8:
  - chase from 8'h80 gives 8'h01.
  - bounce from 8'h01 walks 02…80, then 40, 20 (dir flips at 80). It flips back at 01.
  - Loading 0 in bounce reseeds to 8'h01 at the next tick.
- Blink/pause:
  - mode=3, pat=8'hA5 → 5A → A5 on successive ticks.
  - pause=1 holds 8'hA5 across 3 ticks while `tick` keeps pulsing.
- Load priority: load=1 with load_data=8'h3C in the same cycle as tick_int → pat=8'h3C, not a stepped value. The next step proceeds normally from 8'h3C.
- PWM, with bright=4, PWM_BITS=4, pat=8'hFF:
  - led=8'hFF for exactly 4 of every 16 cycles.
  - bright=0 gives led constant 0.
  - bright=15 gives 15/16 duty.
- Async reset, with rst pulsed low mid-bounce between clock edges: led=0, tick=0 immediately. After release, pat=1, dir=0, and the first tick arrives DIV cycles later.
